// File: rtl/pulse_train_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_gen_pkg
// Description : Shared types and default widths for the pulse train
//               generator: FSM state encoding and default field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_gen_pkg;

  // Default width of the high/low length fields, in cycles.
  localparam int PG_LEN_W = 8;
  // Default width of the pulse-count field.
  localparam int PG_NUM_W = 8;

  // Burst sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } pg_state_t;

endpackage : pulse_gen_pkg
`default_nettype wire

// File: rtl/pulse_train_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : pulse_train_generator_if
// Description : Start handshake, burst fields, abort and waveform outputs of
//               the pulse train generator.
//   start_valid / start_ready : start request handshake
//   high_len / low_len        : per-pulse high and low lengths (0 means 1)
//   num_pulses                : pulses per burst (0 is legal)
//   abort                     : cancel a running burst
//   pulse_out / busy / done   : waveform, in-progress flag, completion strobe
//   master : the requester side, slave : the generator side
// Revision    : 1.0 - initial release
// ============================================================================
interface pulse_train_generator_if
  import pulse_gen_pkg::*;
#(
  parameter int LEN_W = PG_LEN_W,
  parameter int NUM_W = PG_NUM_W
) ();

  logic             start_valid;
  logic             start_ready;
  logic [LEN_W-1:0] high_len;
  logic [LEN_W-1:0] low_len;
  logic [NUM_W-1:0] num_pulses;
  logic             abort;
  logic             pulse_out;
  logic             busy;
  logic             done;

  modport master (
    output start_valid,
    output high_len,
    output low_len,
    output num_pulses,
    output abort,
    input  start_ready,
    input  pulse_out,
    input  busy,
    input  done
  );

  modport slave (
    input  start_valid,
    input  high_len,
    input  low_len,
    input  num_pulses,
    input  abort,
    output start_ready,
    output pulse_out,
    output busy,
    output done
  );

endinterface : pulse_train_generator_if
`default_nettype wire

// File: rtl/pulse_train_generator_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : pulse_phase_counter
// Description : Loadable down-counter that counts toward 1 and never wraps.
//   clk, rst  : clock and asynchronous active-high reset (value -> 0)
//   load      : load load_val (has priority over en)
//   load_val  : value to load
//   en        : decrement by one while the value is non-zero
//   last      : high while the value equals 1
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_phase_counter #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_val,
  input  wire logic             en,
  output logic                  last
);

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= c_zero;
    end else if (load) begin
      r_value <= load_val;
    end else if (en && (r_value != c_zero)) begin
      // Guarded so an idle-enabled counter saturates at 0 instead of wrapping.
      r_value <= r_value - c_one;
    end
  end

  assign last = (r_value == c_one);

endmodule : pulse_phase_counter
`default_nettype wire

// File: rtl/pulse_train_generator.sv
`default_nettype none
// ============================================================================
// Module      : pulse_train_generator
// Description : Emits a burst of N rectangular pulses with programmable high
//               length and low gap, launched by a valid/ready handshake.
//               Every pulse is followed by at least one low cycle.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of pulse_train_generator_if (handshake, fields,
//          abort, pulse_out / busy / done outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_train_generator
  import pulse_gen_pkg::*;
#(
  parameter int LEN_W = PG_LEN_W,
  parameter int NUM_W = PG_NUM_W
) (
  input  wire logic                clk,
  input  wire logic                rst,
  pulse_train_generator_if.slave   bus
);

  localparam logic [LEN_W-1:0] c_len_zero = '0;
  localparam logic [LEN_W-1:0] c_len_one  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_W-1:0] c_num_zero = '0;

  pg_state_t        r_state;
  logic [LEN_W-1:0] r_high_len;
  logic [LEN_W-1:0] r_low_len;

  logic             w_accept;
  logic [LEN_W-1:0] w_high_clamp;
  logic [LEN_W-1:0] w_low_clamp;

  logic             w_phase_load;
  logic [LEN_W-1:0] w_phase_val;
  logic             w_phase_en;
  logic             w_phase_last;

  logic             w_pulse_load;
  logic             w_pulse_en;
  logic             w_pulse_last;

  // --------------------------------------------------------------------------
  // Request acceptance and length clamping (a zero length behaves as one).
  // --------------------------------------------------------------------------
  assign w_accept     = (r_state == IDLE) && bus.start_valid;
  assign w_high_clamp = (bus.high_len == c_len_zero) ? c_len_one : bus.high_len;
  assign w_low_clamp  = (bus.low_len  == c_len_zero) ? c_len_one : bus.low_len;

  // --------------------------------------------------------------------------
  // Counter control. The phase counter is loaded from the live clamped input
  // in the acceptance cycle because the field latches only settle at that
  // same edge; later reloads use the latched copies.
  // --------------------------------------------------------------------------
  always_comb begin
    w_phase_load = 1'b0;
    w_phase_val  = r_high_len;
    w_pulse_load = 1'b0;
    w_pulse_en   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          // The pulse counter doubles as the latched burst count.
          w_pulse_load = 1'b1;
          if (bus.num_pulses != c_num_zero) begin
            w_phase_load = 1'b1;
            w_phase_val  = w_high_clamp;
          end
        end
      end
      HIGH: begin
        if (w_phase_last) begin
          w_phase_load = 1'b1;
          w_phase_val  = r_low_len;
        end
      end
      LOW: begin
        if (w_phase_last) begin
          w_pulse_en = 1'b1;
          if (!w_pulse_last) begin
            w_phase_load = 1'b1;
            w_phase_val  = r_high_len;
          end
        end
      end
      default: begin
        w_phase_load = 1'b0;
      end
    endcase
  end

  assign w_phase_en = (r_state == HIGH) || (r_state == LOW);

  pulse_phase_counter #(
    .WIDTH (LEN_W)
  ) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_phase_load),
    .load_val (w_phase_val),
    .en       (w_phase_en),
    .last     (w_phase_last)
  );

  pulse_phase_counter #(
    .WIDTH (NUM_W)
  ) u_pulse_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_pulse_load),
    .load_val (bus.num_pulses),
    .en       (w_pulse_en),
    .last     (w_pulse_last)
  );

  // --------------------------------------------------------------------------
  // Burst sequencer and field latches.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_high_len <= c_len_zero;
      r_low_len  <= c_len_zero;
    end else begin
      case (r_state)
        IDLE: begin
          // Abort is meaningless here; a simultaneous start is taken.
          if (w_accept) begin
            r_high_len <= w_high_clamp;
            r_low_len  <= w_low_clamp;
            r_state    <= (bus.num_pulses == c_num_zero) ? DONE : HIGH;
          end
        end
        HIGH: begin
          if (bus.abort) begin
            r_state <= IDLE;
          end else if (w_phase_last) begin
            r_state <= LOW;
          end
        end
        LOW: begin
          if (bus.abort) begin
            r_state <= IDLE;
          end else if (w_phase_last) begin
            r_state <= w_pulse_last ? DONE : HIGH;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Moore outputs decoded from the registered state only, so an asynchronous
  // reset forces them to their idle values without waiting for a clock edge.
  // --------------------------------------------------------------------------
  assign bus.pulse_out   = (r_state == HIGH);
  assign bus.busy        = (r_state == HIGH) || (r_state == LOW);
  assign bus.done        = (r_state == DONE);
  assign bus.start_ready = (r_state == IDLE);

endmodule : pulse_train_generator
`default_nettype wire

// File: tb/tb_pulse_train_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_train_generator
// Description : Self-checking bench for pulse_train_generator. Expected
//               per-cycle output vectors {start_ready, busy, done, pulse_out}
//               are queued when a burst is launched and popped each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_train_generator;

  localparam int c_len_w = 8;
  localparam int c_num_w = 8;
  localparam logic [3:0] c_idle = 4'b1000;

  logic clk;
  logic rst;

  int compared   = 0;
  int mismatched = 0;

  logic [3:0] sb_q[$];

  pulse_train_generator_if #(.LEN_W(c_len_w), .NUM_W(c_num_w)) bus ();

  pulse_train_generator #(
    .LEN_W (c_len_w),
    .NUM_W (c_num_w)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Reference model of one burst: vectors for cycles T+1 .. T+N(H+L)+1.
  function automatic void push_burst(input int h, input int l, input int n);
    int hc;
    int lc;
    int per;
    hc  = (h == 0) ? 1 : h;
    lc  = (l == 0) ? 1 : l;
    per = hc + lc;
    for (int j = 1; j <= n * per; j++) begin
      sb_q.push_back({1'b0, 1'b1, 1'b0, (((j - 1) % per) < hc)});
    end
    sb_q.push_back(4'b0010);
  endfunction

  task automatic drive_fields(input int h, input int l, input int n);
    bus.high_len   = h[c_len_w-1:0];
    bus.low_len    = l[c_len_w-1:0];
    bus.num_pulses = n[c_num_w-1:0];
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    rst = 1'b1;
    bus.start_valid = 1'b0;
    bus.abort = 1'b0;
    drive_fields(0, 0, 0);
    @(negedge clk);
    obs = {bus.start_ready, bus.busy, bus.done, bus.pulse_out};
    compared++;
    if (obs !== c_idle) begin
      mismatched++;
      $display("FAIL reset_state: got %b required %b", obs, c_idle);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Single launched burst followed by one idle cycle; counts rising edges.
  task automatic test_burst(input string name, input int h, input int l, input int n);
    logic [3:0] obs;
    logic [3:0] exp;
    logic       prev;
    int         edges;
    int         c;
    prev  = 1'b0;
    edges = 0;
    c     = 0;
    sb_q.delete();
    sb_q.push_back(c_idle);
    push_burst(h, l, n);
    sb_q.push_back(c_idle);
    bus.start_valid = 1'b1;
    drive_fields(h, l, n);
    while (sb_q.size() > 0) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      obs = {bus.start_ready, bus.busy, bus.done, bus.pulse_out};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL %s cycle %0d: got %b required %b", name, c, obs, exp);
      end
      if (bus.pulse_out && !prev) edges++;
      prev = bus.pulse_out;
      @(posedge clk); #1;
      c++;
      if (c == 1) begin
        // Fields may change freely once accepted.
        bus.start_valid = 1'b0;
        drive_fields($urandom_range(255), $urandom_range(255), $urandom_range(255));
      end
    end
    compared++;
    if (edges !== n) begin
      mismatched++;
      $display("FAIL %s_edges: got %0d rising edges required %0d", name, edges, n);
    end
  endtask

  task automatic test_abort();
    logic [3:0] obs;
    logic [3:0] exp;
    int         c;
    c = 0;
    sb_q.delete();
    sb_q.push_back(c_idle);
    push_burst(5, 5, 4);
    bus.start_valid = 1'b1;
    drive_fields(5, 5, 4);
    while (sb_q.size() > 0) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      obs = {bus.start_ready, bus.busy, bus.done, bus.pulse_out};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL abort cycle %0d: got %b required %b", c, obs, exp);
      end
      @(posedge clk); #1;
      c++;
      if (c == 1) bus.start_valid = 1'b0;
      // Cycle 13 is the third high cycle of the second pulse.
      if (c == 13) bus.abort = 1'b1;
      if (c == 14) begin
        bus.abort = 1'b0;
        sb_q.delete();
        sb_q.push_back(c_idle);
        push_burst(2, 1, 1);
        sb_q.push_back(c_idle);
        bus.start_valid = 1'b1;
        drive_fields(2, 1, 1);
      end
      if (c == 15) bus.start_valid = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] obs;
    logic [3:0] exp;
    sb_q.delete();
    sb_q.push_back(c_idle);
    push_burst(4, 4, 2);
    bus.start_valid = 1'b1;
    drive_fields(4, 4, 2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      obs = {bus.start_ready, bus.busy, bus.done, bus.pulse_out};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL async_rst_pre cycle %0d: got %b required %b", c, obs, exp);
      end
      if (c < 2) begin
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
      end
    end
    // Mid-cycle reset during HIGH: outputs must change before any edge.
    #1 rst = 1'b1;
    #1;
    obs = {bus.start_ready, bus.busy, bus.done, bus.pulse_out};
    compared++;
    if (obs !== c_idle) begin
      mismatched++;
      $display("FAIL async_rst_immediate: got %b required %b", obs, c_idle);
    end
    @(posedge clk); #1;
    obs = {bus.start_ready, bus.busy, bus.done, bus.pulse_out};
    compared++;
    if (obs !== c_idle) begin
      mismatched++;
      $display("FAIL async_rst_held: got %b required %b", obs, c_idle);
    end
    rst = 1'b0;
    @(negedge clk);
    obs = {bus.start_ready, bus.busy, bus.done, bus.pulse_out};
    compared++;
    if (obs !== c_idle) begin
      mismatched++;
      $display("FAIL async_rst_release: got %b required %b", obs, c_idle);
    end
    @(posedge clk); #1;
  endtask

  // start_valid held high: each burst takes the fields of its own acceptance
  // cycle, with DONE plus one IDLE cycle between bursts.
  task automatic test_back_to_back();
    logic [3:0] obs;
    logic [3:0] exp;
    int         bursts;
    int         h;
    int         l;
    int         n;
    int         c;
    bursts = 0;
    c      = 0;
    sb_q.delete();
    bus.start_valid = 1'b1;
    while ((bursts < 4) || (sb_q.size() > 0)) begin
      if (sb_q.size() == 0) begin
        if (bursts < 4) begin
          h = $urandom_range(3);
          l = $urandom_range(3);
          n = (bursts == 1) ? 0 : $urandom_range(1, 3);
          drive_fields(h, l, n);
          sb_q.push_back(c_idle);
          push_burst(h, l, n);
          bursts++;
        end else begin
          bus.start_valid = 1'b0;
          sb_q.push_back(c_idle);
        end
      end else begin
        drive_fields($urandom_range(255), $urandom_range(255), $urandom_range(255));
      end
      @(negedge clk);
      exp = sb_q.pop_front();
      obs = {bus.start_ready, bus.busy, bus.done, bus.pulse_out};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL back_to_back cycle %0d: got %b required %b", c, obs, exp);
      end
      @(posedge clk); #1;
      c++;
    end
  endtask

  initial begin
    test_reset();
    test_burst("basic_h1_l1_n3", 1, 1, 3);
    test_burst("clamp_h4_l0_n2", 4, 0, 2);
    test_burst("zero_count", 3, 2, 0);
    test_burst("clamp_h0_l3_n2", 0, 3, 2);
    test_abort();
    test_async_reset();
    test_burst("after_reset", 2, 2, 1);
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_pulse_train_generator
`default_nettype wire

// File: doc/pulse_train_generator.md
# pulse_train_generator

Generates a burst of N rectangular pulses on a single-bit output, each with a programmable high length and low gap. It is launched by a valid/ready start handshake. It is the transmit-side counterpart to the team's edge and pulse detectors, and drives test stimulus and strobe lines consumed by those detectors. Every pulse is followed by at least one low cycle, so downstream edge detectors see each pulse as a distinct event.

## Interface
- `LEN_W`, default 8: width of the high/low length fields, in cycles.
- `NUM_W`, default 8: width of the pulse-count field.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: reset, asynchronous, active-high. Clock `clk`.
- `start_valid  in  1`: request to start a burst.
- `start_ready  out  1`: the generator can accept a request.
- `high_len  in  LEN_W`: high cycles per pulse. 0 is treated as 1.
- `low_len  in  LEN_W`: low cycles after each pulse. 0 is treated as 1.
- `num_pulses  in  NUM_W`: pulses in the burst. 0 is legal.
- `abort  in  1`: synchronous cancel of a running burst.
- `pulse_out  out  1`: the generated waveform.
- `busy  out  1`: a burst is in progress (states HIGH or LOW).
- `done  out  1`: one-cycle strobe when a burst completes normally.

## Operation
- FSM states: IDLE, HIGH, LOW, DONE.
- All outputs are Moore outputs decoded from registered state, with no combinational input-to-output path:
  - `pulse_out` = (state == HIGH)
  - `busy` = HIGH or LOW
  - `done` = DONE
  - `start_ready` = IDLE
- Reset values: state IDLE, so `start_ready`=1 and `pulse_out`=`busy`=`done`=0. All counters and latched fields are 0.
- **IDLE:**
  - On `start_valid` && `start_ready`, latch `high_len`, `low_len` and `num_pulses`, applying the 0→1 clamp to the lengths.
  - `num_pulses`==0 → DONE. Otherwise → HIGH, with the phase counter loaded with the high length and the pulse counter loaded with `num_pulses`.
  - Inputs are ignored while not in IDLE. Field values may change freely after acceptance.
- **HIGH:**
  - The phase counter decrements each cycle.
  - On the last high cycle → LOW, with the phase counter loaded with the low length.
- **LOW:**
  - The phase counter decrements each cycle.
  - On the last low cycle, the pulse counter decrements.
  - If it was the final pulse → DONE. Otherwise → HIGH, reloading the high length.
- **DONE:** lasts exactly one cycle, then → IDLE.
- **abort:**
  - In HIGH or LOW: next state is IDLE, `pulse_out` drops the next cycle, and no `done` is issued.
  - In IDLE or DONE: no effect. A start and an abort in the same IDLE cycle → the start is accepted.
- Counter arithmetic is unsigned with no wrap. Counters load from the latched fields and count down to 1.
- Reset asserted mid-burst: all outputs go to their reset values immediately (asynchronous), and the burst is lost.

## Timing
- Start accepted at the edge ending cycle T. With clamped lengths H and L:
  - Pulse k (k=0..N-1) is high for cycles T+1+k(H+L) through T+k(H+L)+H.
  - It is then low for L cycles.
- `done`=1 in cycle T+N(H+L)+1. `start_ready` is back to 1 in cycle T+N(H+L)+2.
- N=0: `done` in T+1, `start_ready` in T+2, and `pulse_out` stays 0.
- Minimum pulse period is 2 cycles (H=L=1).
- Back-to-back bursts: the start accepted in the first IDLE cycle gives a HIGH in the very next cycle.
- Abort sampled in cycle A (HIGH or LOW) → IDLE and `start_ready`=1 in cycle A+1.

## Structure
- Package `pulse_gen_pkg`:
  - state enum `pg_state_t` with IDLE, HIGH, LOW, DONE
  - default width constants `PG_LEN_W` and `PG_NUM_W`
- Sub-module `pulse_phase_counter`:
  - parameterised down-counter with `load`, `load_val`, `en`, and a `last` flag (value==1)
  - reset async to 0
  - instantiated twice: phase counter (`LEN_W`) and pulse counter (`NUM_W`)
- Top level: FSM plus the field latches.

## Test plan
- Reset: hold `rst` high mid-sim → `pulse_out`=0, `busy`=0, `done`=0, `start_ready`=1 immediately. Assert `rst` during a HIGH phase → `pulse_out` falls without waiting for a clock edge.
- Basic burst: H=1, L=1, N=3 accepted at T → `pulse_out` = 1,0,1,0,1,0 over T+1..T+6, `done` at T+7, `start_ready` at T+8. A rising-edge count of 3 confirms the pulses are distinct.
- Long phases and clamp: H=4, L=0, N=2 → high 4, low 1, high 4, low 1 (10 cycles), `done` at T+11.
- Zero count: N=0 → `pulse_out` never rises, `busy` stays 0, `done` at T+1.
- Abort: H=5, L=5, N=4 with `abort` in the 3rd high cycle of pulse 2 → `pulse_out` 0 and `start_ready` 1 next cycle, and `done` never asserts. A new start in that cycle is accepted.
- Handshake: hold `start_valid` high continuously with changing fields → each burst uses the fields present in its own acceptance cycle, and consecutive bursts are separated by exactly the DONE cycle plus one IDLE cycle.
